// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: writeback wins, MD writes bypass or queue.
// Queued MD writes drain in idle cycles; long waits raise stall_req_o.
module grf_wport_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_addr_i,
   input  logic [31:0] wb_data_i,
   input  logic [31:0] wb_pc_i,
   input  logic        md_valid_i,
   output logic        md_ready_o,
   input  logic [4:0]  md_addr_i,
   input  logic [31:0] md_data_i,
   input  logic [31:0] md_pc_i,
   output logic        grf_we_o,
   output logic [4:0]  grf_a3_o,
   output logic [31:0] grf_wd_o,
   output logic [31:0] grf_pc_o,
   input  logic [4:0]  q_a1_i,
   input  logic [4:0]  q_a2_i,
   output logic        q_hit1_o,
   output logic        q_hit2_o,
   output logic        stall_req_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pc;
   } ent_t;

   ent_t             mem_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW-1:0]    wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             stall_q, stall_d;

   logic empty, full;
   logic wb_req, md_acc;
   logic head_gnt, bypass, push, pop;
   ent_t head, md_ent;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (cnt_q == '0);
   assign full   = (cnt_q == CW'(DEPTH));
   assign head   = mem_q[rd_q];
   assign md_ent = '{addr: md_addr_i, data: md_data_i, pc: md_pc_i};

   // No pop credit: a full FIFO refuses even if the head drains now.
   assign md_ready_o = !full && !reset;
   assign md_acc     = md_valid_i && md_ready_o;

   assign wb_req   = wb_valid_i && (wb_addr_i != 5'd0);
   assign head_gnt = !wb_req && !empty;
   assign bypass   = !wb_req && empty && md_acc
                     && (md_addr_i != 5'd0);
   assign push     = md_acc && (md_addr_i != 5'd0) && !bypass;
   assign pop      = head_gnt;

   always_comb begin
      grf_we_o = 1'b0;
      grf_a3_o = '0;
      grf_wd_o = '0;
      grf_pc_o = '0;
      if (wb_req) begin
         grf_we_o = 1'b1;
         grf_a3_o = wb_addr_i;
         grf_wd_o = wb_data_i;
         grf_pc_o = wb_pc_i;
      end else if (!empty) begin
         grf_we_o = 1'b1;
         grf_a3_o = head.addr;
         grf_wd_o = head.data;
         grf_pc_o = head.pc;
      end else if (bypass) begin
         grf_we_o = 1'b1;
         grf_a3_o = md_addr_i;
         grf_wd_o = md_data_i;
         grf_pc_o = md_pc_i;
      end
   end

   always_comb begin
      q_hit1_o = 1'b0;
      q_hit2_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (mem_q[i].addr == q_a1_i))
            q_hit1_o = 1'b1;
         if (vld_q[i] && (mem_q[i].addr == q_a2_i))
            q_hit2_o = 1'b1;
      end
      if (q_a1_i == 5'd0)
         q_hit1_o = 1'b0;
      if (q_a2_i == 5'd0)
         q_hit2_o = 1'b0;
   end

   always_comb begin
      rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
      wr_d  = push ? ptr_inc(wr_q) : wr_q;
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      starve_d = starve_q;
      if (empty || head_gnt)
         starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT))
         starve_d = starve_q + 1'b1;
      stall_d = stall_q || (starve_d == SW'(STARVE_LIMIT));
      if (head_gnt)
         stall_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q    <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         if (push)
            vld_q[wr_q] <= 1'b1;
         if (pop)
            vld_q[rd_q] <= 1'b0;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         cnt_q    <= cnt_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   // Payload storage needs no reset; vld_q qualifies every entry.
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_q] <= md_ent;
   end

   assign stall_req_o = stall_q;

endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Directed bench for grf_wport_arbiter with a queue-based reference
// model checked every cycle plus literal expectations per step.
module tb_grf_wport_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic [31:0] wb_pc = '0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [4:0]  md_addr = '0;
   logic [31:0] md_data = '0;
   logic [31:0] md_pc = '0;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;
   logic [4:0]  q_a1 = '0;
   logic [4:0]  q_a2 = '0;
   logic        q_hit1, q_hit2;
   logic        stall_req;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   grf_wport_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset(reset),
      .wb_valid_i(wb_valid), .wb_addr_i(wb_addr),
      .wb_data_i(wb_data), .wb_pc_i(wb_pc),
      .md_valid_i(md_valid), .md_ready_o(md_ready),
      .md_addr_i(md_addr), .md_data_i(md_data), .md_pc_i(md_pc),
      .grf_we_o(grf_we), .grf_a3_o(grf_a3),
      .grf_wd_o(grf_wd), .grf_pc_o(grf_pc),
      .q_a1_i(q_a1), .q_a2_i(q_a2),
      .q_hit1_o(q_hit1), .q_hit2_o(q_hit2),
      .stall_req_o(stall_req)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
      end
   endtask

   // Reference model: queued MD writes, blocked-run length, stall bit.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];
   int   m_run = 0;
   bit   m_stall = 0;

   initial begin
      bit          e_rdy, wbr, head_go, byp, push, h1, h2;
      bit          e_we;
      logic [4:0]  e_a3;
      logic [31:0] e_wd, e_pc;
      int          n_run;
      bit          n_stall;
      ent_t        ne;
      forever begin
         @(negedge clk);
         if (reset) begin
            mq.delete();
            m_run = 0;
            m_stall = 0;
         end
         e_rdy = !reset && (mq.size() < DEPTH);
         wbr = wb_valid && (wb_addr != 0);
         head_go = !wbr && (mq.size() > 0);
         byp = !wbr && (mq.size() == 0) && md_valid && e_rdy
               && (md_addr != 0);
         push = md_valid && e_rdy && (md_addr != 0) && !byp;
         e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
         if (wbr) begin
            e_we = 1; e_a3 = wb_addr; e_wd = wb_data; e_pc = wb_pc;
         end else if (head_go) begin
            e_we = 1; e_a3 = mq[0].a; e_wd = mq[0].d; e_pc = mq[0].pc;
         end else if (byp) begin
            e_we = 1; e_a3 = md_addr; e_wd = md_data; e_pc = md_pc;
         end
         h1 = 0; h2 = 0;
         foreach (mq[i]) begin
            if (q_a1 != 0 && mq[i].a == q_a1) h1 = 1;
            if (q_a2 != 0 && mq[i].a == q_a2) h2 = 1;
         end
         chk("m_ready", md_ready, e_rdy);
         chk("m_we", grf_we, e_we);
         chk("m_a3", grf_a3, e_a3);
         chk("m_wd", grf_wd, e_wd);
         chk("m_pc", grf_pc, e_pc);
         chk("m_hit1", q_hit1, h1);
         chk("m_hit2", q_hit2, h2);
         chk("m_stall", stall_req, m_stall);
         if (mq.size() > 0 && !head_go)
            n_run = (m_run + 1 > LIMIT) ? LIMIT : m_run + 1;
         else
            n_run = 0;
         n_stall = head_go ? 0 : (m_stall || n_run == LIMIT);
         ne = '{a: md_addr, d: md_data, pc: md_pc};
         @(posedge clk);
         if (!reset) begin
            if (head_go) void'(mq.pop_front());
            if (push) mq.push_back(ne);
            m_run = n_run;
            m_stall = n_stall;
         end
      end
   end

   task automatic drive(input logic rs, input logic wv,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma,
                        input logic [31:0] mdt);
      @(posedge clk);
      #1;
      reset = rs;
      wb_valid = wv; wb_addr = wa; wb_data = wd;
      wb_pc = 32'h1000 + {27'd0, wa};
      md_valid = mv; md_addr = ma; md_data = mdt;
      md_pc = 32'h2000 + {27'd0, ma};
      #3;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      q_a2 = 5'd10;
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("rst_ready", md_ready, 0);
      chk("rst_we", grf_we, 0);
      chk("rst_stall", stall_req, 0);
      drive(0, 1, 5, 32'h1234, 0, 0, 0);
      chk("wb_we", grf_we, 1);
      chk("wb_a3", grf_a3, 5);
      chk("wb_wd", grf_wd, 32'h1234);
      chk("wb_ready", md_ready, 1);
      q_a1 = 5'd8;
      drive(0, 0, 0, 0, 1, 8, 32'hAAAA);
      chk("byp_a3", grf_a3, 8);
      chk("byp_wd", grf_wd, 32'hAAAA);
      chk("byp_pc", grf_pc, 32'h2008);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("byp_hit1", q_hit1, 0);
      chk("idle_we", grf_we, 0);
      q_a1 = 5'd4;
      drive(0, 1, 3, 32'h33, 1, 4, 32'h44);
      chk("col_a3", grf_a3, 3);
      chk("col_hit_same", q_hit1, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("col_a3b", grf_a3, 4);
      chk("col_wd", grf_wd, 32'h44);
      chk("col_hit", q_hit1, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("col_hit_gone", q_hit1, 0);
      q_a1 = 5'd9;
      drive(0, 1, 1, 32'h11, 1, 9, 32'h99);
      chk("fill_rdy0", md_ready, 1);
      drive(0, 1, 2, 32'h22, 1, 10, 32'h1010);
      chk("fill_rdy1", md_ready, 1);
      chk("fill_hit9", q_hit1, 1);
      drive(0, 1, 1, 32'h11, 1, 11, 32'hBAD);
      chk("fill_full", md_ready, 0);
      chk("fill_hit10", q_hit2, 1);
      drive(0, 1, 2, 32'h22, 0, 0, 0);
      drive(0, 1, 1, 32'h11, 0, 0, 0);
      chk("fill_nostall", stall_req, 0);
      drive(0, 1, 2, 32'h22, 0, 0, 0);
      chk("fill_stall", stall_req, 1);
      chk("fill_wbwins", grf_a3, 2);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drain_a3_9", grf_a3, 9);
      chk("drain_stall_on", stall_req, 1);
      chk("drain_full", md_ready, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drain_a3_10", grf_a3, 10);
      chk("drain_stall_off", stall_req, 0);
      chk("drain_rdy", md_ready, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drain_empty", grf_we, 0);
      drive(0, 1, 1, 32'h11, 1, 0, 32'h5);
      chk("z_md_rdy", md_ready, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("z_md_nowr", grf_we, 0);
      drive(0, 1, 1, 32'h11, 1, 7, 32'h77);
      drive(0, 1, 0, 32'hDEAD, 0, 0, 0);
      chk("z_wb_a3", grf_a3, 7);
      chk("z_wb_wd", grf_wd, 32'h77);
      drive(0, 0, 0, 0, 0, 0, 0);
      q_a1 = 5'd12;
      drive(0, 1, 1, 32'h11, 1, 12, 32'hC);
      drive(0, 1, 2, 32'h22, 1, 13, 32'hD);
      drive(0, 1, 3, 32'h33, 0, 0, 0);
      chk("r_hit_pre", q_hit1, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("r_rdy", md_ready, 0);
      chk("r_we", grf_we, 0);
      chk("r_hit", q_hit1, 0);
      drive(1, 1, 6, 32'h66, 0, 0, 0);
      chk("r_wb", grf_a3, 6);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("r_post_we", grf_we, 0);
      chk("r_post_rdy", md_ready, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("r_post_we2", grf_we, 0);
      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
